// File: rtl/sd_dat_rx.sv
// sd_dat_rx: receives one SD 4-bit DAT-bus read block, packs nibbles into
// 32-bit words for the SD FIFO, and checks per-line CRC16 and the end bit.
module sd_dat_rx #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_strobe,
  input  logic [3:0]  i_sd_dat,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_block_words,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_error,
  output logic        o_timeout,
  output logic        o_fifo_push,
  output logic [31:0] o_fifo_data
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the state is left on that count.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] wait_cnt;
  logic [2:0]    nib_cnt;
  logic [7:0]    word_cnt;
  logic [7:0]    block_words;
  logic [3:0]    crc_cnt;
  logic [27:0]   word_sr;      // first seven nibbles of the word being assembled
  logic [15:0]   crc     [4];
  logic [15:0]   crc_upd [4];
  logic [3:0]    crc_msb;

  logic start_ok;
  logic start_bit;
  logic last_nib;
  logic last_word;

  assign start_ok  = i_start && !i_abort;
  assign start_bit = i_sd_strobe && (i_sd_dat == 4'b0000);
  assign last_nib  = (nib_cnt == 3'd7);
  assign last_word = (word_cnt == block_words - 8'd1);

  // Per-line CRC16-CCITT: serial update while receiving data, then shifted
  // out MSB-first so bit 15 is always the next expected CRC bit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      assign crc_upd[gi] = {crc[gi][14:0], 1'b0} ^
                           ((crc[gi][15] ^ i_sd_dat[gi]) ? 16'h1021 : 16'h0000);
      assign crc_msb[gi] = crc[gi][15];

      // CRC register for this DAT line
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          crc[gi] <= 16'h0000;
        end else if (state == S_IDLE) begin
          if (start_ok) crc[gi] <= 16'h0000;
        end else if (!i_abort && i_sd_strobe) begin
          if (state == S_DATA)     crc[gi] <= crc_upd[gi];
          else if (state == S_CRC) crc[gi] <= {crc[gi][14:0], 1'b0};
        end
      end
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_WAIT_START, S_DATA, S_CRC, S_END: o_busy = 1'b1;
      S_DONE:                             o_done = 1'b1;
      default: ;
    endcase
    if (state != S_IDLE && i_abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) state_next = (i_block_words == 8'd0) ? S_DONE : S_WAIT_START;
        end
        S_WAIT_START: begin
          if (start_bit)                  state_next = S_DATA;
          else if (wait_cnt == WAIT_LAST) state_next = S_DONE;
        end
        S_DATA: begin
          if (i_sd_strobe && last_nib && last_word) state_next = S_CRC;
        end
        S_CRC: begin
          if (i_sd_strobe && crc_cnt == 4'd15) state_next = S_END;
        end
        S_END: begin
          if (i_sd_strobe) state_next = S_DONE;
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: counters, word assembly, FIFO push and sticky flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt    <= '0;
      nib_cnt     <= 3'd0;
      word_cnt    <= 8'd0;
      block_words <= 8'd0;
      crc_cnt     <= 4'd0;
      word_sr     <= 28'd0;
      o_crc_error <= 1'b0;
      o_timeout   <= 1'b0;
      o_fifo_push <= 1'b0;
      o_fifo_data <= 32'd0;
    end else begin
      o_fifo_push <= 1'b0;
      if (state == S_IDLE) begin
        if (start_ok) begin
          wait_cnt    <= '0;
          nib_cnt     <= 3'd0;
          word_cnt    <= 8'd0;
          crc_cnt     <= 4'd0;
          word_sr     <= 28'd0;
          block_words <= i_block_words;
          o_crc_error <= 1'b0;
          o_timeout   <= 1'b0;
        end
      end else if (!i_abort) begin
        case (state)
          S_WAIT_START: begin
            wait_cnt <= wait_cnt + 1'b1;
            if (!start_bit && wait_cnt == WAIT_LAST) o_timeout <= 1'b1;
          end
          S_DATA: begin
            if (i_sd_strobe) begin
              word_sr <= {word_sr[23:0], i_sd_dat};
              nib_cnt <= nib_cnt + 3'd1;
              if (last_nib) begin
                // Word is copied out here so later strobes cannot disturb it.
                o_fifo_push <= 1'b1;
                o_fifo_data <= {word_sr, i_sd_dat};
                word_cnt    <= word_cnt + 8'd1;
              end
            end
          end
          S_CRC: begin
            if (i_sd_strobe) begin
              crc_cnt <= crc_cnt + 4'd1;
              if (i_sd_dat != crc_msb) o_crc_error <= 1'b1;
            end
          end
          S_END: begin
            if (i_sd_strobe && i_sd_dat != 4'b1111) o_crc_error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_rx.sv
// tb_sd_dat_rx: directed and randomized block receptions checked against a
// behavioural model (word list -> nibble stream, per-line CRC from data bits).
module tb_sd_dat_rx;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_sd_strobe;
  logic [3:0]  i_sd_dat;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_block_words;
  logic        o_busy, o_done, o_crc_error, o_timeout, o_fifo_push;
  logic [31:0] o_fifo_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] got[$];
  int   done_cnt = 0;
  logic busy_at_done = 1'b1;

  sd_dat_rx #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_sd_strobe(i_sd_strobe), .i_sd_dat(i_sd_dat),
    .i_start(i_start), .i_abort(i_abort), .i_block_words(i_block_words),
    .o_busy(o_busy), .o_done(o_done), .o_crc_error(o_crc_error), .o_timeout(o_timeout),
    .o_fifo_push(o_fifo_push), .o_fifo_data(o_fifo_data)
  );

  always #5 clk = ~clk;

  // FIFO-side monitor
  always @(negedge clk) begin
    if (o_fifo_push) got.push_back(o_fifo_data);
    if (o_done) begin
      done_cnt++;
      busy_at_done = o_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One strobed sample; leaves 1-2 idle cycles so strobes are never adjacent.
  task automatic strobe(input logic [3:0] d);
    i_sd_dat    = d;
    i_sd_strobe = 1'b1;
    @(posedge clk); #1;
    i_sd_strobe = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int nw);
    got.delete();
    done_cnt      = 0;
    busy_at_done  = 1'b1;
    i_block_words = 8'(nw);
    i_start       = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // CRC16-CCITT of one DAT line, bit-serial over the data bits that line carries.
  function automatic logic [15:0] line_crc(input logic [31:0] w[$], input int line);
    logic [15:0] c = 16'h0000;
    logic b, fb;
    foreach (w[j])
      for (int i = 0; i < 8; i++) begin
        b  = w[j][28 - 4*i + line];
        fb = c[15] ^ b;
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic run_block(input string name, input logic [31:0] w[$], input int n_idle,
                           input int flip_line, input int flip_k, input logic [3:0] end_nib);
    int nw;
    logic [15:0] c[4];
    logic [3:0] nib;
    logic exp_err;
    nw      = w.size();
    exp_err = (flip_line >= 0) || (end_nib != 4'hF);
    for (int n = 0; n < 4; n++) c[n] = line_crc(w, n);
    start_block(nw);
    check({name, "_busy_start"}, 32'(o_busy), 32'd1);
    check({name, "_flags_clr"}, {30'd0, o_crc_error, o_timeout}, 32'd0);
    for (int i = 0; i < n_idle; i++) strobe(4'($urandom_range(1, 15)));
    strobe(4'h0);
    foreach (w[j])
      for (int i = 0; i < 8; i++) strobe(w[j][31 - 4*i -: 4]);
    for (int k = 0; k < 16; k++) begin
      for (int n = 0; n < 4; n++) nib[n] = c[n][15 - k] ^ ((flip_line == n) && (flip_k == k));
      strobe(nib);
    end
    strobe(end_nib);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_busy_in_done"}, 32'(busy_at_done), 32'd0);
    check({name, "_push_cnt"}, 32'(got.size()), 32'(nw));
    for (int j = 0; j < nw && j < got.size(); j++)
      if (got[j] !== w[j]) check($sformatf("%s_word%0d", name, j), got[j], w[j]);
      else tests++;
    check({name, "_crc_err"}, 32'(o_crc_error), 32'(exp_err));
    check({name, "_timeout"}, 32'(o_timeout), 32'd0);
    $display("[TB] block %s words=%0d pushes=%0d crc_error=%0b", name, nw, got.size(), o_crc_error);
  endtask

  initial begin
    logic [31:0] w[$];
    int n;
    i_reset = 1'b1; i_sd_strobe = 1'b0; i_sd_dat = 4'hF;
    i_start = 1'b0; i_abort = 1'b0; i_block_words = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {26'd0, o_busy, o_done, o_crc_error, o_timeout, o_fifo_push, 1'b0}, 32'd0);
    check("reset_data", o_fifo_data, 32'd0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    // 1: single word
    w = '{32'h12345678};
    run_block("one_word", w, 3, -1, 0, 4'hF);

    // 2: 128 words of bytes 0..255 twice
    w.delete();
    for (int j = 0; j < 128; j++)
      w.push_back({8'(4*j), 8'(4*j + 1), 8'(4*j + 2), 8'(4*j + 3)});
    run_block("full_block", w, 2, -1, 0, 4'hF);
    check("full_first", (got.size() > 0) ? got[0] : 32'hx, 32'h00010203);
    check("full_last", (got.size() > 127) ? got[127] : 32'hx, 32'hFCFDFEFF);

    // 3: CRC bit 3 of DAT2 inverted
    w = '{32'h12345678};
    run_block("crc_flip", w, 3, 2, 3, 4'hF);

    // 4: bad end bit, then a clean block clears the flag
    run_block("bad_end", w, 3, -1, 0, 4'hD);
    run_block("after_bad", w, 1, -1, 0, 4'hF);

    // zero-word block goes straight to done
    start_block(0);
    check("zero_done", 32'(o_done), 32'd1);
    check("zero_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    check("zero_done_once", 32'(o_done), 32'd0);
    check("zero_pushes", 32'(got.size()), 32'd0);

    // 5: timeout with DAT idle
    i_sd_dat = 4'hF;
    start_block(1);
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (o_done) begin n = c; break; end
    end
    check("timeout_cycles", 32'(n), 32'd100);
    check("timeout_flag", 32'(o_timeout), 32'd1);
    check("timeout_pushes", 32'(got.size()), 32'd0);
    $display("[TB] timeout done after %0d cycles", n);

    // abort and start together in idle: stay idle
    @(posedge clk); #1;
    i_start = 1'b1; i_abort = 1'b1; i_block_words = 8'd4;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    check("abort_start_idle", 32'(o_busy), 32'd0);

    // 6a: abort after 3 words of 128
    w.delete();
    for (int j = 0; j < 128; j++) w.push_back($urandom);
    start_block(128);
    strobe(4'h0);
    for (int i = 0; i < 26; i++) strobe(w[i/8][31 - 4*(i%8) -: 4]);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 8; i++) strobe(4'($urandom));
    check("abort_pushes", 32'(got.size()), 32'd3);
    for (int j = 0; j < 3 && j < got.size(); j++) check($sformatf("abort_word%0d", j), got[j], w[j]);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    $display("[TB] abort after %0d pushes", got.size());

    // 6b: reset mid-DATA
    start_block(128);
    strobe(4'h0);
    for (int i = 0; i < 19; i++) strobe(w[i/8][31 - 4*(i%8) -: 4]);
    #2 i_reset = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    for (int i = 0; i < 10; i++) strobe(4'($urandom));
    check("rst_pushes", 32'(got.size()), 32'd2);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    $display("[TB] reset mid-block after %0d pushes", got.size());

    // randomized blocks
    for (int t = 0; t < 6; t++) begin
      int fl;
      logic [3:0] en;
      w.delete();
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) w.push_back($urandom);
      fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      run_block($sformatf("rand%0d", t), w, $urandom_range(0, 3), fl, $urandom_range(0, 15), en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
